// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback definitions: register index width, pipeline requester index,
// the generic writeback request record and a helper for the x0 write suppression.
package wb_pkg;

   localparam int REG_IDX_W = 5;
   localparam int REQ_PIPE  = 0;
   localparam int WB_XLEN   = 32;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_req_t;

   // A write to x0 completes the handshake but never reaches the register file.
   function automatic logic rd_writes(input logic [REG_IDX_W-1:0] rd);
      return rd != {REG_IDX_W{1'b0}};
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Rotating first-valid finder over requesters 1..NUM_REQ-1.
// The search starts at rr_ptr and wraps from NUM_REQ-1 back to 1; index 0 is never
// considered. Purely combinational so arbiters can fold it into their grant logic.
module wb_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               found,
   output logic [PTR_W-1:0]   idx
);

   int               pos_s;
   logic [PTR_W-1:0] pos_idx_s;
   logic             hit_s;

   // Walk the rotated order and latch the first valid requester seen.
   always_comb begin
      found     = 1'b0;
      idx       = {PTR_W{1'b0}};
      pos_s     = 0;
      pos_idx_s = {PTR_W{1'b0}};
      hit_s     = 1'b0;
      for (int off = 0; off < NUM_REQ - 1; off++) begin
         pos_s = int'(rr_ptr) - 1 + off;
         pos_s = (pos_s >= NUM_REQ - 1) ? (pos_s - (NUM_REQ - 1)) : pos_s;
         pos_s = pos_s + 1;
         pos_idx_s = PTR_W'(pos_s);
         hit_s     = valid[pos_idx_s];
         idx       = (!found && hit_s) ? pos_idx_s : idx;
         found     = found | hit_s;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Requester 0 is the MEM/WB pipeline stage and wins
// by default; requesters 1..NUM_REQ-1 are multi-cycle units served round-robin and
// forced through (stalling the pipeline) after STARVE_LIMIT consecutive denials.
// The register-file write is registered: one write per cycle, latency 1.
// Optional build macro WB_HAZARD_CHK_EN adds a sticky err_o flag for two valid
// requesters presenting the same nonzero destination register.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*REG_IDX_W-1:0] req_rd_i,
   input  logic [NUM_REQ*XLEN-1:0]      req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic                         stall_o,
   output logic                         rf_we_o,
   output logic [REG_IDX_W-1:0]         rf_rd_o,
   output logic [XLEN-1:0]              rf_data_o
`ifdef WB_HAZARD_CHK_EN
   ,output logic                        err_o
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [PTR_W-1:0]     rr_ptr_r;
   logic [CNT_W-1:0]     starve_cnt_r;
   logic                 cand_found_s;
   logic [PTR_W-1:0]     cand_idx_s;
   logic                 starve_full_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic [PTR_W-1:0]     gidx_s;
   logic                 xfer_s;
   logic                 stall_s;
   logic                 unit_grant_s;
   logic [REG_IDX_W-1:0] sel_rd_s;
   logic [XLEN-1:0]      sel_data_s;

   wb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .valid  (req_valid_i),
      .rr_ptr (rr_ptr_r),
      .found  (cand_found_s),
      .idx    (cand_idx_s)
   );

   assign starve_full_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));
   assign unit_grant_s  = xfer_s && !grant_s[REQ_PIPE];
   assign req_ready_o   = grant_s;
   assign stall_o       = stall_s;

   // Grant decision: starved unit first, then the pipeline, then any waiting unit.
   always_comb begin
      grant_s = {NUM_REQ{1'b0}};
      gidx_s  = {PTR_W{1'b0}};
      xfer_s  = 1'b0;
      stall_s = 1'b0;
      if (starve_full_s && cand_found_s) begin
         grant_s[cand_idx_s] = 1'b1;
         gidx_s              = cand_idx_s;
         xfer_s              = 1'b1;
         stall_s             = req_valid_i[REQ_PIPE];
      end else if (req_valid_i[REQ_PIPE]) begin
         grant_s[REQ_PIPE] = 1'b1;
         gidx_s            = PTR_W'(REQ_PIPE);
         xfer_s            = 1'b1;
      end else if (cand_found_s) begin
         grant_s[cand_idx_s] = 1'b1;
         gidx_s              = cand_idx_s;
         xfer_s              = 1'b1;
      end else begin
         xfer_s = 1'b0;
      end
   end

   // Route the granted requester's destination and data towards the write register.
   always_comb begin
      sel_rd_s   = {REG_IDX_W{1'b0}};
      sel_data_s = {XLEN{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_rd_s   = (gidx_s == PTR_W'(k)) ? req_rd_i[k*REG_IDX_W +: REG_IDX_W] : sel_rd_s;
         sel_data_s = (gidx_s == PTR_W'(k)) ? req_data_i[k*XLEN +: XLEN] : sel_data_s;
      end
   end

   // Starvation counter and round-robin pointer for the multi-cycle units.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= {CNT_W{1'b0}};
         rr_ptr_r     <= PTR_W'(1);
      end else begin
         if (cand_found_s && grant_s[REQ_PIPE]) begin
            starve_cnt_r <= starve_full_s ? starve_cnt_r : (starve_cnt_r + CNT_W'(1));
         end else if (!cand_found_s || unit_grant_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
         if (unit_grant_s) begin
            rr_ptr_r <= (gidx_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : (gidx_s + PTR_W'(1));
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Registered register-file write; address and data hold when nothing transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_o   <= 1'b0;
         rf_rd_o   <= {REG_IDX_W{1'b0}};
         rf_data_o <= {XLEN{1'b0}};
      end else if (xfer_s) begin
         rf_we_o   <= rd_writes(sel_rd_s);
         rf_rd_o   <= sel_rd_s;
         rf_data_o <= sel_data_s;
      end else begin
         rf_we_o   <= 1'b0;
         rf_rd_o   <= rf_rd_o;
         rf_data_o <= rf_data_o;
      end
   end

`ifdef WB_HAZARD_CHK_EN
   logic hazard_s;

   // Detect two valid requesters targeting the same nonzero register.
   always_comb begin
      hazard_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = i + 1; j < NUM_REQ; j++) begin
            hazard_s = hazard_s | (req_valid_i[i] && req_valid_i[j] &&
                       (req_rd_i[i*REG_IDX_W +: REG_IDX_W] == req_rd_i[j*REG_IDX_W +: REG_IDX_W]) &&
                       rd_writes(req_rd_i[i*REG_IDX_W +: REG_IDX_W]));
         end
      end
   end

   // Sticky hazard flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else begin
         err_o <= err_o | hazard_s;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (NUM_REQ=3, XLEN=32, STARVE_LIMIT=4).
// A behavioural arbiter model predicts ready/stall each cycle and pushes the
// expected register-file write into a queue that is popped one cycle later.
module tb_wb_port_arbiter;

   localparam int NR = 3;
   localparam int XL = 32;
   localparam int SL = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*5-1:0] req_rd;
   logic [NR*XL-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            stall;
   logic            rf_we;
   logic [4:0]      rf_rd;
   logic [XL-1:0]   rf_data;
`ifdef WB_HAZARD_CHK_EN
   logic            err;
`endif

   always #5 clk = ~clk;

   wb_port_arbiter #(.NUM_REQ(NR), .XLEN(XL), .STARVE_LIMIT(SL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_rd_i    (req_rd),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .stall_o     (stall),
      .rf_we_o     (rf_we),
      .rf_rd_o     (rf_rd),
      .rf_data_o   (rf_data)
`ifdef WB_HAZARD_CHK_EN
      ,.err_o      (err)
`endif
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_ptr;
   int          m_cnt;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        m_err;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [31:0] d);
      req_valid[k]       = v;
      req_rd[k*5 +: 5]   = rd;
      req_data[k*XL +: XL] = d;
   endtask

   task automatic model_reset();
      m_ptr  = 1;
      m_cnt  = 0;
      m_rd   = 5'd0;
      m_data = 32'd0;
      m_err  = 1'b0;
      exp_q.delete();
   endtask

   // One arbitration cycle: compare ready/stall mid-cycle, then the registered write.
   task automatic step(output logic [NR-1:0] rdy_seen, output logic stall_seen);
      int       cand;
      int       grant;
      int       k;
      logic     stall_e;
      logic [NR-1:0] rdy_e;
      exp_t     e;
      exp_t     got;
      @(negedge clk);
      cand = -1;
      for (int off = 0; off < NR - 1; off++) begin
         k = ((m_ptr - 1 + off) % (NR - 1)) + 1;
         if (cand < 0 && req_valid[k]) cand = k;
      end
      grant   = -1;
      stall_e = 1'b0;
      if (m_cnt == SL && cand >= 0) begin
         grant   = cand;
         stall_e = req_valid[0];
      end else if (req_valid[0]) begin
         grant = 0;
      end else if (cand >= 0) begin
         grant = cand;
      end
      rdy_e = '0;
      if (grant >= 0) rdy_e[grant] = 1'b1;
      check_eq("ready", req_ready, rdy_e);
      check_eq("stall", stall, stall_e);
      for (int i = 0; i < NR; i++)
         for (int j = i + 1; j < NR; j++)
            if (req_valid[i] && req_valid[j] && req_rd[i*5 +: 5] == req_rd[j*5 +: 5] && req_rd[i*5 +: 5] != 5'd0)
               m_err = 1'b1;
      if (cand >= 0 && grant == 0) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
      else if (grant > 0 || cand < 0) m_cnt = 0;
      if (grant > 0) m_ptr = (grant == NR - 1) ? 1 : grant + 1;
      if (grant >= 0) begin
         m_rd   = req_rd[grant*5 +: 5];
         m_data = req_data[grant*XL +: XL];
         e.we   = (m_rd != 5'd0);
      end else begin
         e.we = 1'b0;
      end
      e.rd   = m_rd;
      e.data = m_data;
      e.err  = m_err;
      exp_q.push_back(e);
      rdy_seen   = req_ready;
      stall_seen = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 64'd1, 64'd0);
      end else begin
         got = exp_q.pop_front();
         check_eq("rf_we", rf_we, got.we);
         check_eq("rf_rd", rf_rd, got.rd);
         check_eq("rf_data", rf_data, got.data);
`ifdef WB_HAZARD_CHK_EN
         check_eq("err", err, got.err);
`endif
      end
   endtask

   logic [NR-1:0] rdy;
   logic [NR-1:0] prev_rdy;
   logic          st;
   logic [NR-1:0] t3_rdy [6];
   logic          t3_stall [6];

   initial begin
      t3_rdy   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
      t3_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      rst_n     = 1'b0;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_we", rf_we, 1'b0);
      check_eq("reset_rd", rf_rd, 5'd0);
      check_eq("reset_data", rf_data, 32'd0);
      check_eq("reset_ready", req_ready, 3'b000);
      rst_n = 1'b1;

      // Reset in the middle of a registered write discards it at once.
      set_req(0, 1'b1, 5'd3, 32'h1234_5678);
      step(rdy, st);
      check_eq("pre_reset_we", rf_we, 1'b1);
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      check_eq("async_reset_we", rf_we, 1'b0);
      check_eq("async_reset_rd", rf_rd, 5'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Only requester 1 after reset, then pointer must favour requester 2.
      set_req(1, 1'b1, 5'd9, 32'hAAAA_0001);
      step(rdy, st);
      check_eq("t1_grant1", rdy, 3'b010);
      set_req(1, 1'b1, 5'd10, 32'hAAAA_0002);
      set_req(2, 1'b1, 5'd11, 32'hBBBB_0001);
      step(rdy, st);
      check_eq("t1_rr_ptr2", rdy, 3'b100);
      prev_rdy = rdy;

      // Units 1 and 2 always valid, pipeline idle: grants alternate, no stall.
      for (int c = 0; c < 4; c++) begin
         for (int k = 1; k < NR; k++)
            if (rdy[k]) set_req(k, 1'b1, 5'(k * 4 + c), 32'hC000_0000 + 32'(c));
         step(rdy, st);
         check_eq("t4_alternate", (rdy != prev_rdy) && (rdy[0] == 1'b0), 1'b1);
         check_eq("t4_no_stall", st, 1'b0);
         prev_rdy = rdy;
      end
      req_valid = '0;

      // Pipeline write with the registered result one cycle later.
      set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      step(rdy, st);
      check_eq("t2_ready0", rdy, 3'b001);
      check_eq("t2_we", rf_we, 1'b1);
      check_eq("t2_rd", rf_rd, 5'd5);
      check_eq("t2_data", rf_data, 32'hDEAD_BEEF);
      req_valid = '0;

      // x0 destination: handshake completes but no write.
      set_req(1, 1'b1, 5'd0, 32'h0BAD_F00D);
      step(rdy, st);
      check_eq("t5_ready1", rdy, 3'b010);
      check_eq("t5_no_we", rf_we, 1'b0);
      req_valid = '0;
      step(rdy, st);

      // Starvation: pipeline and unit 1 continuously valid.
      set_req(1, 1'b1, 5'd12, 32'h1111_0000);
      for (int c = 0; c < 6; c++) begin
         set_req(0, 1'b1, 5'(20 + c), 32'h2222_0000 + 32'(c));
         step(rdy, st);
         check_eq("t3_ready", rdy, t3_rdy[c]);
         check_eq("t3_stall", st, t3_stall[c]);
         if (rdy[1]) set_req(1, 1'b1, 5'd13, 32'h1111_0001);
      end
      req_valid = '0;
      step(rdy, st);

      // Random traffic obeying the hold-until-ready handshake.
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < NR; k++)
            if (!req_valid[k] && $urandom_range(0, 2) != 0)
               set_req(k, 1'b1, 5'($urandom_range(0, 7)), $urandom);
         step(rdy, st);
         for (int k = 0; k < NR; k++)
            if (rdy[k]) req_valid[k] = 1'b0;
      end
      req_valid = '0;

`ifdef WB_HAZARD_CHK_EN
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("t6_err_reset", err, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_req(0, 1'b1, 5'd7, 32'h7777_0000);
      set_req(2, 1'b1, 5'd7, 32'h7777_0002);
      step(rdy, st);
      check_eq("t6_err_set", err, 1'b1);
      req_valid = '0;
      repeat (3) step(rdy, st);
      check_eq("t6_err_sticky", err, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
